// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus between the MEM pipeline stage, the SRAM controller and the 16-bit SRAM pins.
// The master side is the pipeline/SRAM pair and the slave side is the controller.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface mem_stage_sram_ctrl_if;
    logic                    MEM_R_EN;
    logic                    MEM_W_EN;
    logic [`ADDRESS_LEN-1:0] ALU_Res;
    logic [`WORD_LEN-1:0]    Val_Rm;
    logic [`WORD_LEN-1:0]    memory_out;
    logic                    ready;
    logic [17:0]             SRAM_ADDR;
    logic [15:0]             SRAM_DQ_OUT;
    logic                    SRAM_DQ_OE;
    logic [15:0]             SRAM_DQ_IN;
    logic                    SRAM_WE_N;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_DQ_IN,
        input  memory_out, ready, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_DQ_IN,
        output memory_out, ready, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting each 32-bit access into two 16-bit SRAM phases (LO, HI).
// Optional read bypass buffer enabled by defining macro MEM_RD_BYPASS_EN.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_BASE   = 1024
) (
    input logic                 clk,
    input logic                 rst,
    mem_stage_sram_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0]              LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [`ADDRESS_LEN-1:0] BASE = `ADDRESS_LEN'(DATA_BASE);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [15:0]         rdLo_q;
    logic [`WORD_LEN-1:0] memOut_q;
    logic [17:0]         addr_q;
    logic [15:0]         dqOut_q;
    logic                dqOe_q;
    logic                weN_q;

    logic [16:0] wordAddr;
    logic        isWrite;
    logic        request;
    logic        hit;
    logic        start;
    logic        phaseLast;

    assign wordAddr  = 17'((bus.ALU_Res - BASE) >> 2);
    // A simultaneous read and write request is served as a read only.
    assign isWrite   = bus.MEM_W_EN & ~bus.MEM_R_EN;
    assign request   = bus.MEM_R_EN | bus.MEM_W_EN;
    assign start     = (state_q == IDLE) && request && !hit;
    assign phaseLast = (cnt_q == LAST);

    assign bus.ready       = ((state_q == IDLE) && (!request || hit)) || (state_q == DONE);
    assign bus.memory_out  = memOut_q;
    assign bus.SRAM_ADDR   = addr_q;
    assign bus.SRAM_DQ_OUT = dqOut_q;
    assign bus.SRAM_DQ_OE  = dqOe_q;
    assign bus.SRAM_WE_N   = weN_q;

`ifdef MEM_RD_BYPASS_EN
    logic                    bypValid_q;
    logic [`ADDRESS_LEN-1:0] bypAddr_q;

    assign hit = (state_q == IDLE) && bus.MEM_R_EN && bypValid_q && (bypAddr_q == bus.ALU_Res);

    always_ff @(posedge clk) begin
        if (rst) begin
            bypValid_q <= 1'b0;
            bypAddr_q  <= '0;
        end else if (start && isWrite) begin
            bypValid_q <= 1'b0;
        end else if ((state_q == HI) && phaseLast && !isWrite) begin
            bypValid_q <= 1'b1;
            bypAddr_q  <= bus.ALU_Res;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Pin outputs are registered, so each transition loads the values for the coming cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdLo_q   <= '0;
            memOut_q <= '0;
            addr_q   <= '0;
            dqOut_q  <= '0;
            dqOe_q   <= 1'b0;
            weN_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LO;
                        cnt_q   <= '0;
                        addr_q  <= {wordAddr, 1'b0};
                        if (isWrite) begin
                            dqOe_q  <= 1'b1;
                            weN_q   <= 1'b0;
                            dqOut_q <= bus.Val_Rm[15:0];
                        end
                    end
                end
                LO: begin
                    if (phaseLast) begin
                        state_q <= HI;
                        cnt_q   <= '0;
                        addr_q  <= {wordAddr, 1'b1};
                        if (isWrite) begin
                            weN_q   <= 1'b0;
                            dqOut_q <= bus.Val_Rm[31:16];
                        end else begin
                            rdLo_q <= bus.SRAM_DQ_IN;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (isWrite) weN_q <= (cnt_q + 4'd1 == LAST);
                    end
                end
                HI: begin
                    if (phaseLast) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        weN_q   <= 1'b1;
                        dqOe_q  <= 1'b0;
                        if (!isWrite) memOut_q <= {bus.SRAM_DQ_IN, rdLo_q};
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (isWrite) weN_q <= (cnt_q + 4'd1 == LAST);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: cycles per 16-bit SRAM half-access; legal range 2..15.
REQ-002 Parameter DATA_BASE, default 1024: byte address of data-memory word 0.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 MEM_R_EN  in  1  load request from EXE stage register.
REQ-006 MEM_W_EN  in  1  store request from EXE stage register.
REQ-007 ALU_Res  in  `ADDRESS_LEN  byte address, word aligned.
REQ-008 Val_Rm  in  `WORD_LEN  store data.
REQ-009 memory_out  out  `WORD_LEN  load result, feeds the MEM stage register.
REQ-010 ready  out  1  high when no access is outstanding; pipeline freeze = ~ready.
REQ-011 SRAM_ADDR  out  18  halfword address.
REQ-012 SRAM_DQ_OUT  out  16  write data; SRAM_DQ_OE  out  1  drive enable.
REQ-013 SRAM_DQ_IN  in  16  read data.
REQ-014 SRAM_WE_N  out  1  active-low write strobe.

Function
REQ-015 Word address WA = (ALU_Res - DATA_BASE) >> 2, truncated to 17 bits; SRAM_ADDR = {WA, half}, half = 0 for low, 1 for high.
REQ-016 FSM states: IDLE, LO, HI, DONE; one counter counts cycles in LO/HI.
REQ-017 IDLE: MEM_R_EN or MEM_W_EN (and not a bypass hit) -> LO next cycle; otherwise stay.
REQ-018 LO and HI each last exactly WAIT_CYCLES cycles; LO -> HI -> DONE -> IDLE; DONE lasts 1 cycle.
REQ-019 ready = 1 in IDLE with no request, 1 in DONE, 0 otherwise (combinational from state and requests).
REQ-020 Access latency: request first presented in cycle 0 -> ready high in cycle 2*WAIT_CYCLES+1 (cycle 5 at default).
REQ-021 Inputs are held stable by the frozen pipeline while ready = 0; the block does not re-latch them.
REQ-022 Read: SRAM_DQ_IN sampled on the last LO cycle into bits 15:0, on the last HI cycle into bits 31:16; memory_out updates at DONE entry and holds until the next read completes.
REQ-023 Write: SRAM_DQ_OE = 1 in all LO/HI cycles; SRAM_DQ_OUT = Val_Rm[15:0] in LO, Val_Rm[31:16] in HI; SRAM_WE_N = 0 on the first WAIT_CYCLES-1 cycles of each phase and 1 on the last.
REQ-024 SRAM_WE_N = 1 and SRAM_DQ_OE = 0 in IDLE, in DONE and for all reads.
REQ-025 MEM_R_EN and MEM_W_EN both high: treated as a read; the write is dropped.
REQ-026 Requests arriving while the FSM is not in IDLE are not observed until the FSM returns to IDLE.

Reset
REQ-027 rst forces IDLE, counter 0, memory_out 0, SRAM_WE_N 1, SRAM_DQ_OE 0, SRAM_ADDR 0, SRAM_DQ_OUT 0, bypass valid 0.
REQ-028 rst in any state aborts the access on that edge; no further write strobe follows.
REQ-029 ready is 1 in the first cycle after reset if no request is present.

Configuration
REQ-030 With macro MEM_RD_BYPASS_EN defined, the last completed read address is stored with a valid bit; the bit is set at DONE of a read and cleared at LO entry of any write.
REQ-031 With MEM_RD_BYPASS_EN defined, a read in IDLE with a valid, equal address is a hit: ready = 1 in the same cycle, memory_out is unchanged, no SRAM cycle starts and the FSM stays in IDLE.
REQ-032 Without MEM_RD_BYPASS_EN, no buffer is built and every read takes the full latency.

Verification
REQ-033 Write Val_Rm=0xDEADBEEF to ALU_Res=1028 -> SRAM_ADDR 2 then 3; DQ_OUT 0xBEEF then 0xDEAD; WE_N low one cycle per phase; ready high in cycle 5.
REQ-034 Read 1028 with SRAM model returning 0xBEEF/0xDEAD -> memory_out=0xDEADBEEF with ready high in cycle 5; DQ_OE stays 0.
REQ-035 Assert rst during HI of a write -> next cycle IDLE, WE_N=1, DQ_OE=0, memory_out=0, ready=1.
REQ-036 MEM_R_EN and MEM_W_EN both high at 1024 -> no WE_N pulse; memory_out loaded from SRAM.
REQ-037 With MEM_RD_BYPASS_EN: read 1028, then read 1028 again -> second read ready=1 in cycle 0; then write 1028 and read 1028 -> full 5-cycle latency.
REQ-038 WAIT_CYCLES=4 read -> ready high in cycle 9; low half sampled in cycle 4, high half in cycle 8.
